// File: rtl/button_conditioner.sv
// Push-button front end: polarity fix, 2-flop synchroniser, debounce, and
// press/release/long-press strobes plus a saturating hold-duration counter.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES     = 1024,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_raw,
    output logic        btn_state,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_pulse,
    output logic [15:0] hold_count
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [15:0]      LONG_PRE = 16'(LONG_CYCLES - 1);
    localparam logic [15:0]      HOLD_SAT = 16'hFFFF;

    logic             btn_in_s;
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             state_q;
    logic             state_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             long_q;
    logic             long_d;
    logic [15:0]      hold_q;
    logic [15:0]      hold_d;
    logic             diff_s;
    logic             accept_s;
    logic             holding_s;

    assign btn_in_s = btn_raw ^ ACTIVE_LOW;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce, strobe generation and hold-duration next-state logic.
    always_comb begin
        diff_s    = sync2_q ^ state_q;
        accept_s  = diff_s && (cnt_q == CNT_MAX);
        cnt_d     = cnt_q;
        state_d   = state_q ^ accept_s;
        press_d   = accept_s && !state_q;
        release_d = accept_s && state_q;
        // Still pressed after this edge: the release edge freezes the count.
        holding_s = state_q && !release_d;
        hold_d    = hold_q;
        long_d    = holding_s && (hold_q == LONG_PRE);

        if (!diff_s) begin
            cnt_d = CNT_ZERO;
        end else if (accept_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (press_d) begin
            hold_d = 16'h0000;
        end else if (holding_s && (hold_q != HOLD_SAT)) begin
            hold_d = hold_q + 16'h0001;
        end else begin
            hold_d = hold_q;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= CNT_ZERO;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            hold_q    <= 16'h0000;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            hold_q    <= hold_d;
        end
    end

    assign btn_state     = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign hold_count    = hold_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=8.
module tb_button_conditioner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_raw = 1'b0;
    logic        btn_state;
    logic        press_pulse;
    logic        release_pulse;
    logic        long_pulse;
    logic [15:0] hold_count;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (8),
        .ACTIVE_LOW     (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_state    (btn_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .hold_count   (hold_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {state, press, release, long}
    function automatic logic [3:0] flags();
        return {btn_state, press_pulse, release_pulse, long_pulse};
    endfunction

    int longs;
    int long_at;

    initial begin
        // Reset state
        #1;
        check_eq("rst_flags", {28'd0, flags()}, 32'd0);
        check_eq("rst_hold", {16'd0, hold_count}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle_flags", {28'd0, flags()}, 32'd0);
            check_eq("idle_hold", {16'd0, hold_count}, 32'd0);
        end

        // Clean press: accepted on edge 6
        btn_raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("press_wait", {28'd0, flags()}, 32'd0);
        end
        tick();
        check_eq("press_e6_flags", {28'd0, flags()}, 32'b1100);
        check_eq("press_e6_hold", {16'd0, hold_count}, 32'd0);
        tick();
        check_eq("press_e7_flags", {28'd0, flags()}, 32'b1000);
        check_eq("press_e7_hold", {16'd0, hold_count}, 32'd1);

        // Long press: hold until hold_count reaches 20, long fires once at 8
        longs = 0;
        long_at = 0;
        for (int k = 2; k <= 20; k++) begin
            tick();
            check_eq("long_hold", {16'd0, hold_count}, k);
            if (long_pulse) begin
                longs = longs + 1;
                long_at = k;
            end
        end
        check_eq("long_count", longs, 32'd1);
        check_eq("long_at", long_at, 32'd8);

        // Release: counts on while debouncing, then freezes at 25
        btn_raw = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("rel_wait_rp", {31'd0, release_pulse}, 32'd0);
            check_eq("rel_wait_hold", {16'd0, hold_count}, 20 + i);
        end
        tick();
        check_eq("rel_flags", {28'd0, flags()}, 32'b0010);
        check_eq("rel_hold", {16'd0, hold_count}, 32'd25);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rel_after_flags", {28'd0, flags()}, 32'd0);
            check_eq("rel_freeze", {16'd0, hold_count}, 32'd25);
        end

        // Bounce 1,0,1,0 then steady 1: press on 6th edge after last rise
        btn_raw = 1'b1; tick();
        check_eq("bnc_p", {31'd0, press_pulse}, 32'd0);
        btn_raw = 1'b0; tick();
        check_eq("bnc_p", {31'd0, press_pulse}, 32'd0);
        btn_raw = 1'b1; tick();
        check_eq("bnc_p", {31'd0, press_pulse}, 32'd0);
        btn_raw = 1'b0; tick();
        check_eq("bnc_p", {31'd0, press_pulse}, 32'd0);
        btn_raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("bnc_wait", {28'd0, flags()}, 32'd0);
        end
        tick();
        check_eq("bnc_press", {28'd0, flags()}, 32'b1100);
        tick();
        check_eq("bnc_single", {28'd0, flags()}, 32'b1000);
        btn_raw = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        tick();
        check_eq("bnc_rel", {28'd0, flags()}, 32'b0010);
        check_eq("bnc_rel_hold", {16'd0, hold_count}, 32'd6);
        for (int i = 0; i < 4; i++) tick();

        // Short glitch: 3 cycles high is rejected
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("glitch_hi", {28'd0, flags()}, 32'd0);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("glitch_lo", {28'd0, flags()}, 32'd0);
        end

        // Reset mid-press at hold_count=5
        btn_raw = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("mid_press", {31'd0, press_pulse}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("mid_state", {31'd0, btn_state}, 32'd1);
        check_eq("mid_hold", {16'd0, hold_count}, 32'd5);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_flags", {28'd0, flags()}, 32'd0);
        check_eq("mid_rst_hold", {16'd0, hold_count}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("rerst_wait", {28'd0, flags()}, 32'd0);
        end
        tick();
        check_eq("rerst_press", {28'd0, flags()}, 32'b1100);
        check_eq("rerst_hold0", {16'd0, hold_count}, 32'd0);
        tick();
        check_eq("rerst_hold1", {16'd0, hold_count}, 32'd1);
        check_eq("rerst_flags", {28'd0, flags()}, 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
